branch_target_unit: RTL and testbench
=====================================

Name: branch_target_unit

Overview:
Parametrised successor to the combinational PC-plus-immediate adder. Computes the control-transfer target for four modes:
- PC-relative
- register-relative (JALR-style)
- return, predicted via an internal return-address stack (RAS)
- sequential

Result goes into one registered output stage with valid/ready handshake, flush and misalignment flag. Sits between decode and the fetch-redirect logic.

Parameters:
XLEN, 32, datapath width of pc/imm/rs1/target/link.
RAS_DEPTH, 4, return-address stack entries (power of two, >=2).
IALIGN_BYTES, 4, required target alignment in bytes (2 or 4).

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  synchronous active-low reset.
in_valid  input  1  request valid.
in_ready  output  1  unit can accept request this cycle.
mode  input  2  0=PC_REL, 1=REG_REL, 2=RETURN, 3=SEQ.
is_call  input  1  push link address onto RAS when accepted.
pc  input  XLEN  PC of the transfer instruction.
imm  input  XLEN  sign-extended immediate.
rs1  input  XLEN  base register value.
flush  input  1  pipeline flush.
out_valid  output  1  target valid.
out_ready  input  1  consumer accepts target.
target  output  XLEN  computed target.
link  output  XLEN  pc + 4 of accepted request.
misaligned  output  1  target not IALIGN_BYTES-aligned.
ras_used  output  1  RETURN target taken from RAS (not fallback).

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n. On rst_n=0 at a rising edge:
  - out_valid, target, link, misaligned and ras_used are all 0.
  - RAS count and pointer are 0; RAS entry contents are don't-care.
  - Reset mid-transaction discards the held output.
- Handshake:
  - in_ready = !flush && (!out_valid || out_ready).
  - Accept = in_valid && in_ready.
  - Latency is exactly 1 cycle: accept at edge N gives out_valid=1 after edge N.
  - Held output is stable while out_valid && !out_ready.
  - Back-to-back accept gives full throughput.
- Flush: out_valid=0 after the edge. No request is accepted that cycle. RAS is not modified and not rolled back.
- Target arithmetic (all sums modulo 2^XLEN, wrap silently):
  - PC_REL: pc + imm.
  - REG_REL: (rs1 + imm) with bit 0 cleared.
  - RETURN: RAS top if count>0 (ras_used=1); else (rs1 + imm) with bit 0 cleared (ras_used=0).
  - SEQ: pc + 4.
- link = pc + 4 for every accepted request.
- misaligned = (target mod IALIGN_BYTES) != 0, registered with target. With IALIGN_BYTES=2 it is always 0 after bit-0 clear in REG_REL/RETURN.
- RAS (circular buffer, updated only on accept):
  - RETURN, not call: pop. ptr decrements; count decrements, floor 0. Pop on empty leaves state unchanged.
  - is_call, not RETURN: push link. ptr increments mod RAS_DEPTH; count saturates at RAS_DEPTH. Overflow overwrites the oldest entry.
  - RETURN with is_call: replace the top entry with link. count unchanged; if count=0 it becomes 1.
  - Target uses the RAS state from before the update.

Decomposition:
- Shared package bt_pkg:
  - mode enum (BT_PC_REL, BT_REG_REL, BT_RETURN, BT_SEQ).
  - localparam LINK_OFFSET=4.
- One sub-module, bt_ras:
  - Parameters: XLEN, RAS_DEPTH.
  - Ports: push, pop, wdata, top, empty, clk, rst_n.
- Top level holds the target mux, alignment check and output register.

Test Plan:
1. Reset, then PC_REL with pc=0x1000, imm=0xFFFFFFF0 -> next cycle out_valid=1, target=0x00000FF0, link=0x1004, misaligned=0.
2. REG_REL with rs1=0x2003, imm=0 -> target=0x2002, misaligned=1 (IALIGN_BYTES=4); wrap case pc=0xFFFFFFFC, PC_REL imm=8 -> target=0x4.
3. Five calls (pc=0x100, 0x200, 0x300, 0x400, 0x500; DEPTH=4), then five RETURNs -> targets 0x504, 0x404, 0x304, 0x204 with ras_used=1. Fifth RETURN falls back to rs1+imm with ras_used=0.
4. out_ready=0 for 3 cycles with request pending -> in_ready=0, target held stable, no RAS change; release -> next request accepted the same cycle out_ready=1.
5. flush asserted with in_valid=1, is_call=1 -> out_valid=0 next cycle, request not accepted, RAS count unchanged.
6. rst_n=0 while out_valid=1 and RAS count=3 -> all outputs 0; a following RETURN uses the fallback, ras_used=0.

Source files
------------

// File: rtl/bt_pkg.sv
// Shared types and constants for the branch target unit.
package bt_pkg;

  typedef enum logic [1:0] {
    BT_PC_REL  = 2'd0,
    BT_REG_REL = 2'd1,
    BT_RETURN  = 2'd2,
    BT_SEQ     = 2'd3
  } bt_mode_e;

  localparam int LINK_OFFSET = 4;

endpackage

// File: rtl/bt_ras.sv
// Circular return-address stack: push, pop, or push+pop (replace top).
// Overflow silently overwrites the oldest entry; pop on empty is ignored.
module bt_ras
  import bt_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] top,
  output logic            empty
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic [XLEN-1:0]  mem [RAS_DEPTH];
  logic [PTR_W-1:0] ptr;
  logic [CNT_W-1:0] count;

  // ptr always indexes the current top entry.
  assign top   = mem[ptr];
  assign empty = (count == '0);

  // NOTE: the entry array has no reset; its contents are don't-care until
  // count says an entry is live, so it can map onto plain storage.
  always_ff @(posedge clk) begin
    if (push && pop) begin
      mem[ptr] <= wdata;
    end else if (push) begin
      mem[ptr + 1'b1] <= wdata;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every always_ff reads the pre-edge values regardless of evaluation order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr   <= '0;
      count <= '0;
    end else if (push && pop) begin
      if (count == '0) count <= CNT_W'(1);
    end else if (push) begin
      ptr <= ptr + 1'b1;
      if (count != CNT_W'(RAS_DEPTH)) count <= count + 1'b1;
    end else if (pop && count != '0) begin
      ptr   <= ptr - 1'b1;
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/branch_target_unit.sv
// Control-transfer target computation with a return-address stack and a
// single registered valid/ready output stage.
module branch_target_unit
  import bt_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int RAS_DEPTH    = 4,
  parameter int IALIGN_BYTES = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      mode,
  input  logic            is_call,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] target,
  output logic [XLEN-1:0] link,
  output logic            misaligned,
  output logic            ras_used
);

  localparam int ALIGN_BITS = $clog2(IALIGN_BYTES);

  bt_mode_e        req_mode;
  logic            accept;
  logic            ras_empty;
  logic [XLEN-1:0] ras_top;
  logic [XLEN-1:0] next_link;
  logic [XLEN-1:0] reg_target;
  logic [XLEN-1:0] next_target;
  logic            next_used;

  assign req_mode   = bt_mode_e'(mode);
  assign in_ready   = !flush && (!out_valid || out_ready);
  assign accept     = in_valid && in_ready;
  assign next_link  = pc + XLEN'(LINK_OFFSET);
  assign reg_target = (rs1 + imm) & ~XLEN'(1);

  // The RAS is read before its own update, so a RETURN sees the old top.
  bt_ras #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept && is_call),
    .pop   (accept && req_mode == BT_RETURN),
    .wdata (next_link),
    .top   (ras_top),
    .empty (ras_empty)
  );

  // NOTE: every variable gets a default before the case so no path through
  // the block can leave it unassigned and infer a latch.
  always_comb begin
    next_target = next_link;
    next_used   = 1'b0;
    case (req_mode)
      BT_PC_REL:  next_target = pc + imm;
      BT_REG_REL: next_target = reg_target;
      BT_RETURN: begin
        next_used   = !ras_empty;
        next_target = ras_empty ? reg_target : ras_top;
      end
      default:    next_target = next_link;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      target     <= '0;
      link       <= '0;
      misaligned <= 1'b0;
      ras_used   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      target     <= next_target;
      link       <= next_link;
      misaligned <= |next_target[ALIGN_BITS-1:0];
      ras_used   <= next_used;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_branch_target_unit.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences
// and random traffic against a queue-based reference model.
module tb_branch_target_unit;
  import bt_pkg::*;

  localparam int XLEN         = 32;
  localparam int RAS_DEPTH    = 4;
  localparam int IALIGN_BYTES = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      mode;
  logic            is_call;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] rs1;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] link;
  logic            misaligned;
  logic            ras_used;

  always #5 clk = ~clk;

  branch_target_unit #(
    .XLEN         (XLEN),
    .RAS_DEPTH    (RAS_DEPTH),
    .IALIGN_BYTES (IALIGN_BYTES)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .mode       (mode),
    .is_call    (is_call),
    .pc         (pc),
    .imm        (imm),
    .rs1        (rs1),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .target     (target),
    .link       (link),
    .misaligned (misaligned),
    .ras_used   (ras_used)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: the RAS is an ordered list of return addresses,
  // newest at the back, capped at RAS_DEPTH by dropping the oldest.
  logic [XLEN-1:0] ras_q[$];
  logic            m_valid = 1'b0;
  logic            m_after_reset = 1'b0;
  logic [XLEN-1:0] m_target = '0;
  logic [XLEN-1:0] m_link = '0;
  logic            m_mis = 1'b0;
  logic            m_used = 1'b0;

  typedef struct {
    logic [1:0]      md;
    logic            call;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] exp_target;
    logic [XLEN-1:0] exp_link;
    logic            exp_mis;
    logic            exp_used;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [XLEN-1:0] act,
                       input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] md, input logic c,
                       input logic [XLEN-1:0] p, input logic [XLEN-1:0] i,
                       input logic [XLEN-1:0] r);
    in_valid = v;
    mode     = md;
    is_call  = c;
    pc       = p;
    imm      = i;
    rs1      = r;
  endtask

  // One clock: check in_ready, advance the model, then check the outputs.
  task automatic cycle(input string tag);
    logic            exp_ready;
    logic            acc;
    logic            used;
    logic [XLEN-1:0] sum_clr;
    logic [XLEN-1:0] t;
    logic [XLEN-1:0] lk;
    #1;
    exp_ready = !flush && (!m_valid || out_ready);
    check({tag, " in_ready"}, XLEN'(in_ready), XLEN'(exp_ready));
    acc     = in_valid && exp_ready;
    sum_clr = (rs1 + imm) & ~32'h1;
    lk      = pc + 32'd4;
    used    = 1'b0;
    case (mode)
      2'd0: t = pc + imm;
      2'd1: t = sum_clr;
      2'd2: begin
        if (ras_q.size() > 0) begin
          t    = ras_q[$];
          used = 1'b1;
        end else begin
          t = sum_clr;
        end
      end
      default: t = lk;
    endcase
    @(posedge clk);
    if (!rst_n) begin
      m_valid       = 1'b0;
      m_target      = '0;
      m_link        = '0;
      m_mis         = 1'b0;
      m_used        = 1'b0;
      m_after_reset = 1'b1;
      ras_q.delete();
    end else begin
      m_after_reset = 1'b0;
      if (flush) begin
        m_valid = 1'b0;
      end else if (acc) begin
        m_valid  = 1'b1;
        m_target = t;
        m_link   = lk;
        m_mis    = (t % IALIGN_BYTES) != 0;
        m_used   = used;
        if (mode == 2'd2 && is_call) begin
          if (ras_q.size() == 0) ras_q.push_back(lk);
          else ras_q[ras_q.size() - 1] = lk;
        end else if (mode == 2'd2) begin
          if (ras_q.size() > 0) void'(ras_q.pop_back());
        end else if (is_call) begin
          ras_q.push_back(lk);
          if (ras_q.size() > RAS_DEPTH) void'(ras_q.pop_front());
        end
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
    end
    #1;
    check({tag, " out_valid"}, XLEN'(out_valid), XLEN'(m_valid));
    if (m_valid || m_after_reset) begin
      check({tag, " target"}, target, m_target);
      check({tag, " link"}, link, m_link);
      check({tag, " misaligned"}, XLEN'(misaligned), XLEN'(m_mis));
      check({tag, " ras_used"}, XLEN'(ras_used), XLEN'(m_used));
    end
  endtask

  initial begin
    vecs[0]  = '{2'd0, 1'b0, 32'h1000, 32'hFFFFFFF0, 32'h0, 32'h0FF0, 32'h1004, 1'b0, 1'b0};
    vecs[1]  = '{2'd1, 1'b0, 32'h2000, 32'h0, 32'h2003, 32'h2002, 32'h2004, 1'b1, 1'b0};
    vecs[2]  = '{2'd0, 1'b0, 32'hFFFFFFFC, 32'h8, 32'h0, 32'h4, 32'h0, 1'b0, 1'b0};
    vecs[3]  = '{2'd3, 1'b0, 32'h3002, 32'h0, 32'h0, 32'h3006, 32'h3006, 1'b1, 1'b0};
    vecs[4]  = '{2'd2, 1'b0, 32'h40, 32'h11, 32'h4000, 32'h4010, 32'h44, 1'b0, 1'b0};
    vecs[5]  = '{2'd0, 1'b1, 32'h100, 32'h20, 32'h0, 32'h120, 32'h104, 1'b0, 1'b0};
    vecs[6]  = '{2'd0, 1'b1, 32'h200, 32'h20, 32'h0, 32'h220, 32'h204, 1'b0, 1'b0};
    vecs[7]  = '{2'd0, 1'b1, 32'h300, 32'h20, 32'h0, 32'h320, 32'h304, 1'b0, 1'b0};
    vecs[8]  = '{2'd0, 1'b1, 32'h400, 32'h20, 32'h0, 32'h420, 32'h404, 1'b0, 1'b0};
    vecs[9]  = '{2'd0, 1'b1, 32'h500, 32'h20, 32'h0, 32'h520, 32'h504, 1'b0, 1'b0};
    vecs[10] = '{2'd2, 1'b0, 32'h600, 32'h0, 32'h7001, 32'h504, 32'h604, 1'b0, 1'b1};
    vecs[11] = '{2'd2, 1'b0, 32'h600, 32'h0, 32'h7001, 32'h404, 32'h604, 1'b0, 1'b1};
    vecs[12] = '{2'd2, 1'b0, 32'h600, 32'h0, 32'h7001, 32'h304, 32'h604, 1'b0, 1'b1};
    vecs[13] = '{2'd2, 1'b0, 32'h600, 32'h0, 32'h7001, 32'h204, 32'h604, 1'b0, 1'b1};
    vecs[14] = '{2'd2, 1'b0, 32'h600, 32'h0, 32'h7001, 32'h7000, 32'h604, 1'b0, 1'b0};
    vecs[15] = '{2'd2, 1'b1, 32'h800, 32'h4, 32'h900, 32'h904, 32'h804, 1'b0, 1'b0};
    vecs[16] = '{2'd2, 1'b0, 32'hA00, 32'h0, 32'h0, 32'h804, 32'hA04, 1'b0, 1'b1};
    vecs[17] = '{2'd1, 1'b0, 32'h10, 32'h3, 32'hFFFFFFFF, 32'h2, 32'h14, 1'b1, 1'b0};

    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 2'd0, 1'b0, '0, '0, '0);
    cycle("reset");
    cycle("reset2");
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      drive(1'b1, vecs[i].md, vecs[i].call, vecs[i].pc, vecs[i].imm, vecs[i].rs1);
      cycle($sformatf("vec%0d", i));
      check($sformatf("vec%0d table_target", i), target, vecs[i].exp_target);
      check($sformatf("vec%0d table_link", i), link, vecs[i].exp_link);
      check($sformatf("vec%0d table_mis", i), XLEN'(misaligned), XLEN'(vecs[i].exp_mis));
      check($sformatf("vec%0d table_used", i), XLEN'(ras_used), XLEN'(vecs[i].exp_used));
    end

    // Backpressure: held output stable, pending RETURN must not touch the RAS.
    drive(1'b0, 2'd0, 1'b0, '0, '0, '0);
    cycle("bp_drain");
    out_ready = 1'b0;
    drive(1'b1, BT_PC_REL, 1'b1, 32'hB00, 32'h0, 32'h0);
    cycle("bp_first");
    drive(1'b1, BT_RETURN, 1'b0, 32'hB80, 32'h0, 32'h9000);
    for (int k = 0; k < 3; k++) begin
      cycle("bp_hold");
      check("bp_hold target_const", target, 32'hB00);
      check("bp_hold in_ready_low", XLEN'(in_ready), '0);
    end
    out_ready = 1'b1;
    cycle("bp_release");
    check("bp_release target_const", target, 32'hB04);
    check("bp_release used_const", XLEN'(ras_used), 32'h1);

    // Flush with a call pending: not accepted, RAS untouched.
    drive(1'b1, BT_PC_REL, 1'b1, 32'hC00, 32'h0, 32'h0);
    cycle("fl_call");
    flush = 1'b1;
    drive(1'b1, BT_PC_REL, 1'b1, 32'hD00, 32'h0, 32'h0);
    cycle("fl_flush");
    check("fl_flush out_valid_const", XLEN'(out_valid), '0);
    flush = 1'b0;
    drive(1'b1, BT_RETURN, 1'b0, 32'hE00, 32'h0, 32'h5000);
    cycle("fl_ret1");
    check("fl_ret1 target_const", target, 32'hC04);
    cycle("fl_ret2");
    check("fl_ret2 target_const", target, 32'h5000);
    check("fl_ret2 used_const", XLEN'(ras_used), '0);

    // Reset with a live output and three stacked return addresses.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, BT_PC_REL, 1'b1, 32'hE00 + 32'(k * 16), 32'h0, 32'h0);
      cycle("rs_call");
    end
    rst_n = 1'b0;
    drive(1'b0, 2'd0, 1'b0, '0, '0, '0);
    cycle("rs_reset");
    check("rs_reset out_valid_const", XLEN'(out_valid), '0);
    check("rs_reset target_const", target, '0);
    rst_n = 1'b1;
    drive(1'b1, BT_RETURN, 1'b0, 32'hF00, 32'h0, 32'h6000);
    cycle("rs_ret");
    check("rs_ret target_const", target, 32'h6000);
    check("rs_ret used_const", XLEN'(ras_used), '0);

    // Random traffic, biased towards calls and returns to stress the RAS.
    for (int n = 0; n < 600; n++) begin
      drive(($urandom % 4) != 0, 2'($urandom_range(0, 3)), ($urandom % 3) == 0,
            $urandom, ($urandom % 2) ? 32'($urandom_range(0, 64)) - 32'd32 : $urandom,
            $urandom);
      flush     = ($urandom % 16) == 0;
      out_ready = ($urandom % 4) != 0;
      cycle("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
